// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-stage hazard controller bus.
// master: pipeline datapath side (drives decode instruction/status, receives controls)
// slave : pipe_hazard_ctrl side
//   instr_decode, valid_decode, br_true, ext_stall  -> controller
//   stall_fetch, stall_decode, bubble_exe, flush_fetch, pc_sel, imm_sel,
//   reg_write_en, stall_cnt                         <- controller
`ifndef IMM_SEL_I
`define IMM_SEL_WIDTH 3
`define IMM_SEL_I 3'd0
`define IMM_SEL_S 3'd1
`define IMM_SEL_B 3'd2
`define IMM_SEL_U 3'd3
`define IMM_SEL_J 3'd4
`endif

interface pipe_hazard_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    logic [XLEN-1:0]           instr_decode;
    logic                      valid_decode;
    logic                      br_true;
    logic                      ext_stall;
    logic                      stall_fetch;
    logic                      stall_decode;
    logic                      bubble_exe;
    logic                      flush_fetch;
    logic [1:0]                pc_sel;
    logic [`IMM_SEL_WIDTH-1:0] imm_sel;
    logic                      reg_write_en;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output instr_decode, valid_decode, br_true, ext_stall,
        input  stall_fetch, stall_decode, bubble_exe, flush_fetch,
               pc_sel, imm_sel, reg_write_en, stall_cnt
    );

    modport slave (
        input  instr_decode, valid_decode, br_true, ext_stall,
        output stall_fetch, stall_decode, bubble_exe, flush_fetch,
               pc_sel, imm_sel, reg_write_en, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage sequencing controller for a 5-stage RV32I pipeline.
// Tracks EXE/MEM/WB destination registers in a shadow scoreboard, stalls
// decode on RAW hazards, redirects fetch for decode-resolved branches/jumps,
// selects the immediate format and counts hazard stall cycles.
// Ports: clk, rst (sync, active high), hz (pipe_hazard_ctrl_if.slave).
`ifndef IMM_SEL_I
`define IMM_SEL_WIDTH 3
`define IMM_SEL_I 3'd0
`define IMM_SEL_S 3'd1
`define IMM_SEL_B 3'd2
`define IMM_SEL_U 3'd3
`define IMM_SEL_J 3'd4
`endif

module pipe_hazard_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned WB_BYPASS = 0,
    parameter int unsigned CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
    } sb_entry_t;

    sb_entry_t ex_q, mem_q, wb_q, new_entry;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       uses_rs1, uses_rs2, writes_any, writes_rd;
    logic       is_branch, is_jal, is_jalr;
    logic [`IMM_SEL_WIDTH-1:0] imm_sel_c;
    logic       wb_cmp, hit_rs1, hit_rs2, hazard;
    logic       unused_bits;

    assign opcode = hz.instr_decode[6:0];
    assign rd     = hz.instr_decode[11:7];
    assign rs1    = hz.instr_decode[19:15];
    assign rs2    = hz.instr_decode[24:20];
    assign unused_bits = ^{hz.instr_decode[XLEN-1:25], hz.instr_decode[14:12]};

    // Opcode class decode; unknown opcodes fall through as a NOP.
    always_comb begin
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        writes_any = 1'b0;
        is_branch  = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        imm_sel_c  = `IMM_SEL_I;
        case (opcode)
            OPC_LOAD:   begin uses_rs1 = 1'b1; writes_any = 1'b1; end
            OPC_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_sel_c = `IMM_SEL_S; end
            OPC_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; is_branch = 1'b1; imm_sel_c = `IMM_SEL_B; end
            OPC_JAL:    begin writes_any = 1'b1; is_jal = 1'b1; imm_sel_c = `IMM_SEL_J; end
            OPC_JALR:   begin uses_rs1 = 1'b1; writes_any = 1'b1; is_jalr = 1'b1; end
            OPC_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_any = 1'b1; end
            OPC_OPIMM:  begin uses_rs1 = 1'b1; writes_any = 1'b1; end
            OPC_LUI:    begin writes_any = 1'b1; imm_sel_c = `IMM_SEL_U; end
            OPC_AUIPC:  begin writes_any = 1'b1; imm_sel_c = `IMM_SEL_U; end
            default:    ;
        endcase
    end

    assign writes_rd = writes_any & (rd != 5'd0);

    function automatic logic stage_hit(input sb_entry_t e, input logic [4:0] rs);
        return e.valid & e.wr & (e.rd == rs);
    endfunction

    // A write-through regfile already delivers the WB result to decode.
    assign wb_cmp  = (WB_BYPASS == 0);
    assign hit_rs1 = uses_rs1 & (rs1 != 5'd0) &
                     (stage_hit(ex_q, rs1) | stage_hit(mem_q, rs1) | (wb_cmp & stage_hit(wb_q, rs1)));
    assign hit_rs2 = uses_rs2 & (rs2 != 5'd0) &
                     (stage_hit(ex_q, rs2) | stage_hit(mem_q, rs2) | (wb_cmp & stage_hit(wb_q, rs2)));
    assign hazard  = hz.valid_decode & (hit_rs1 | hit_rs2);

    // Entry for EXE: the decode instruction only if it actually issues.
    always_comb begin
        new_entry = '0;
        if (hz.valid_decode && !hazard) begin
            new_entry.valid = 1'b1;
            new_entry.rd    = rd;
            new_entry.wr    = writes_rd;
        end
    end

    // Scoreboard shift and saturating hazard counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else if (!hz.ext_stall) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= new_entry;
            if (hazard && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Control outputs; reset forces a quiet, non-stalling pipeline.
    always_comb begin
        hz.stall_decode = 1'b0;
        hz.stall_fetch  = 1'b0;
        hz.bubble_exe   = 1'b0;
        hz.pc_sel       = 2'd0;
        hz.flush_fetch  = 1'b0;
        hz.imm_sel      = `IMM_SEL_I;
        hz.reg_write_en = 1'b0;
        if (!rst) begin
            hz.stall_decode = hazard | hz.ext_stall;
            hz.stall_fetch  = hazard | hz.ext_stall;
            hz.bubble_exe   = hazard & ~hz.ext_stall;
            hz.imm_sel      = imm_sel_c;
            hz.reg_write_en = wb_q.valid & wb_q.wr;
            if (hz.valid_decode && !hazard && !hz.ext_stall) begin
                if (is_jal)
                    hz.pc_sel = 2'd2;
                else if (is_jalr)
                    hz.pc_sel = 2'd3;
                else if (is_branch && hz.br_true)
                    hz.pc_sel = 2'd1;
            end
            hz.flush_fetch = (hz.pc_sel != 2'd0);
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
endmodule
